// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory load/store controller.
// Size codes, controller states and big-endian lane offsets.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    // Big-endian: byte offset 0 is the most significant lane.
    localparam logic [1:0] OFF_B0 = 2'd0;
    localparam logic [1:0] OFF_B1 = 2'd1;
    localparam logic [1:0] OFF_B2 = 2'd2;
    localparam logic [1:0] OFF_B3 = 2'd3;
    localparam logic [1:0] OFF_H0 = OFF_B0;
    localparam logic [1:0] OFF_H1 = OFF_B2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_DONE,
        ST_ERR
    } state_t;

    // Right-shift that brings byte lane `off` down to bits 7:0.
    function automatic logic [4:0] lane_shift(input logic [1:0] off);
        return {~off, 3'b000};
    endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Big-endian lane extract/extend for loads and lane merge for stores.
// Purely combinational; shared with the instruction-fetch path.
module mem_lane_unit
    import mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        sext_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] store_o
);

    logic [4:0]  shamt;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] byte_mask;
    logic [31:0] half_mask;
    logic [31:0] byte_ins;
    logic [31:0] half_ins;

    always_comb begin
        shamt     = lane_shift(off_i);
        byte_sel  = 8'(word_i >> shamt);
        half_sel  = (off_i == OFF_H1) ? word_i[15:0] : word_i[31:16];
        byte_mask = 32'h0000_00FF << shamt;
        half_mask = (off_i == OFF_H1) ? 32'h0000_FFFF : 32'hFFFF_0000;
        byte_ins  = {24'h0, wdata_i[7:0]} << shamt;
        half_ins  = (off_i == OFF_H1) ? {16'h0, wdata_i[15:0]}
                                      : {wdata_i[15:0], 16'h0};
        load_o    = word_i;
        store_o   = wdata_i;
        unique case (1'b1)
            size_i == SZ_BYTE: begin
                load_o  = {{24{sext_i & byte_sel[7]}}, byte_sel};
                store_o = (word_i & ~byte_mask) | byte_ins;
            end
            size_i == SZ_HALF: begin
                load_o  = {{16{sext_i & half_sel[15]}}, half_sel};
                store_o = (word_i & ~half_mask) | half_ins;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator-side load/store controller for the word-ported data memory.
// Issues only aligned word accesses; sub-word stores use read-modify-write.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] mem_a,
    output logic        mem_we,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        sext_q, sext_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] rdata_q, rdata_d;

    logic [32:0] word_end;
    logic        out_of_range;
    logic        bad_req;
    logic [31:0] lane_word;
    logic [31:0] load_val;
    logic [31:0] store_word;

    // Range and alignment are judged on the live inputs in IDLE.
    always_comb begin
        word_end     = {1'b0, addr[31:2], 2'b00} + 33'd4;
        out_of_range = word_end > 33'(MEM_BYTES);
        bad_req      = (size == SZ_ILL)
                     | ((size == SZ_HALF) & addr[0])
                     | ((size == SZ_WORD) & (|addr[1:0]))
                     | out_of_range;
    end

    assign lane_word = (state_q == ST_RD) ? mem_rd : merge_q;

    mem_lane_unit u_lane (
        .word_i  (lane_word),
        .off_i   (addr_q[1:0]),
        .size_i  (size_q),
        .sext_i  (sext_q),
        .wdata_i (wdata_q),
        .load_o  (load_val),
        .store_o (store_word)
    );

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        sext_d  = sext_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        merge_d = merge_q;
        rdata_d = rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    we_d    = we;
                    size_d  = size;
                    sext_d  = sext;
                    addr_d  = addr;
                    wdata_d = wdata;
                    if (bad_req) begin
                        state_d = ST_ERR;
                    end else if (we && size == SZ_WORD) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (we_q) begin
                    merge_d = mem_rd;
                    state_d = ST_WR;
                end else begin
                    rdata_d = load_val;
                    state_d = ST_DONE;
                end
            end
            ST_WR:   state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            sext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            merge_q <= merge_d;
            rdata_q <= rdata_d;
        end
    end

    // All strobes decode the state register only, so they cannot glitch on req/addr.
    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE) || (state_q == ST_ERR);
    assign err    = (state_q == ST_ERR);
    assign mem_we = (state_q == ST_WR);
    assign mem_a  = {addr_q[31:2], 2'b00};
    assign mem_wd = (state_q == ST_WR) ? store_word : '0;
    assign rdata  = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a word-wide memory model.
// Driver pushes expectations; a forked monitor checks each completion.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] mem_a;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] mem [0:31] = '{2: 32'h1122_3344, 3: 32'h80FF_7F01, default: 32'h0};

    typedef struct {
        logic        err;
        int          lat;
        logic [31:0] rdata;
        int          nwe;
        logic [31:0] wa;
        logic [31:0] wd;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    exp_t e;
    int   a;
    int   cyc = 0;
    int   we_cnt = 0;
    int   acc_total = 0;
    int   tests = 0;
    int   fails = 0;
    int   base;
    int   n;

    always #5 clk = ~clk;

    assign mem_rd = (mem_a < 32'd128) ? mem[mem_a[6:2]] : 32'h0;

    always @(posedge clk) begin
        if (mem_we) mem[mem_a[6:2]] <= mem_wd;
    end

    mem_access_ctrl #(.MEM_BYTES(100)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .we     (we),
        .size   (size),
        .sext   (sext),
        .addr   (addr),
        .wdata  (wdata),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .rdata  (rdata),
        .mem_a  (mem_a),
        .mem_we (mem_we),
        .mem_wd (mem_wd),
        .mem_rd (mem_rd)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic issue(input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] ad, input logic [31:0] wd,
                         input logic e_err, input int lat, input logic [31:0] rd,
                         input int nwe, input logic [31:0] wa, input logic [31:0] wdx);
        exp_t x;
        int   k;
        k = 0;
        while (busy && k < 30) begin
            @(posedge clk); #1;
            k++;
        end
        if (busy) chk("idle_timeout", {31'b0, busy}, 32'd0);
        x.err = e_err; x.lat = lat; x.rdata = rd;
        x.nwe = nwe; x.wa = wa; x.wd = wdx;
        exp_q.push_back(x);
        req = 1'b1; we = w; size = sz; sext = sx; addr = ad; wdata = wd;
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    initial begin
        reset = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00;
        sext = 1'b0; addr = '0; wdata = '0;
        fork
            forever begin
                @(negedge clk);
                cyc++;
                if (reset) begin
                    if (mem_we) begin
                        we_cnt++;
                        if (exp_q.size() > 0) begin
                            chk("mem_a", mem_a, exp_q[0].wa);
                            chk("mem_wd", mem_wd, exp_q[0].wd);
                        end
                    end
                    if (done) begin
                        if (exp_q.size() == 0 || acc_q.size() == 0) begin
                            chk("unexpected_done", {31'b0, done}, 32'd0);
                        end else begin
                            e = exp_q.pop_front();
                            a = acc_q.pop_front();
                            chk("err", {31'b0, err}, {31'b0, e.err});
                            chk("latency", 32'(cyc - a), 32'(e.lat));
                            chk("rdata", rdata, e.rdata);
                            chk("mem_we_cycles", 32'(we_cnt), 32'(e.nwe));
                        end
                        we_cnt = 0;
                    end
                    if (req && !busy) begin
                        acc_q.push_back(cyc);
                        acc_total++;
                    end
                end
            end
        join_none

        #12;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_wd", mem_wd, 32'd0);
        @(negedge clk); #2 reset = 1'b1;
        @(posedge clk); #1;

        // w sz sx addr wdata | err lat rdata nwe wa wd
        issue(0, 2'b00, 1, 32'h0C, 0, 0, 2, 32'hFFFF_FF80, 0, 0, 0);
        issue(0, 2'b00, 0, 32'h0C, 0, 0, 2, 32'h0000_0080, 0, 0, 0);
        issue(0, 2'b01, 1, 32'h0E, 0, 0, 2, 32'h0000_7F01, 0, 0, 0);
        issue(0, 2'b01, 1, 32'h0C, 0, 0, 2, 32'hFFFF_80FF, 0, 0, 0);
        issue(1, 2'b00, 0, 32'h09, 32'hAB, 0, 3, 32'hFFFF_80FF, 1, 32'h08, 32'h11AB_3344);
        issue(0, 2'b10, 0, 32'h08, 0, 0, 2, 32'h11AB_3344, 0, 0, 0);
        issue(1, 2'b10, 0, 32'h10, 32'hDEAD_BEEF, 0, 2, 32'h11AB_3344, 1, 32'h10, 32'hDEAD_BEEF);
        issue(1, 2'b01, 0, 32'h12, 32'h1234, 0, 3, 32'h11AB_3344, 1, 32'h10, 32'hDEAD_1234);
        issue(0, 2'b10, 0, 32'h60, 0, 0, 2, 32'h0, 0, 0, 0);
        issue(0, 2'b10, 0, 32'h10, 0, 0, 2, 32'hDEAD_1234, 0, 0, 0);
        issue(0, 2'b10, 0, 32'h06, 0, 1, 1, 32'hDEAD_1234, 0, 0, 0);
        issue(0, 2'b01, 1, 32'h03, 0, 1, 1, 32'hDEAD_1234, 0, 0, 0);
        issue(0, 2'b11, 0, 32'h00, 0, 1, 1, 32'hDEAD_1234, 0, 0, 0);
        issue(1, 2'b11, 0, 32'h04, 32'h55, 1, 1, 32'hDEAD_1234, 0, 0, 0);
        issue(0, 2'b10, 0, 32'h64, 0, 1, 1, 32'hDEAD_1234, 0, 0, 0);

        // req held high: one access per IDLE visit, address latched at accept
        n = 0;
        while (busy && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        e.err = 0; e.lat = 2; e.nwe = 0; e.wa = 0; e.wd = 0;
        e.rdata = 32'h80FF_7F01; exp_q.push_back(e);
        e.rdata = 32'h11AB_3344; exp_q.push_back(e);
        base = acc_total;
        req = 1'b1; we = 1'b0; size = 2'b10; sext = 1'b0; addr = 32'h0C;
        @(posedge clk); #1;
        addr = 32'h08;
        n = 0;
        while (acc_total < base + 2 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        req = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("held_req_accepts", 32'(acc_total - base), 32'd2);

        issue(0, 2'b00, 1, 32'h0D, 0, 0, 2, 32'hFFFF_FFFF, 0, 0, 0);
        issue(0, 2'b00, 0, 32'h0F, 0, 0, 2, 32'h0000_0001, 0, 0, 0);

        // reset during the write phase of a byte store
        issue(1, 2'b00, 0, 32'h0B, 32'h55, 0, 3, 32'h0, 1, 32'h08, 32'h11AB_3355);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_we && n < 10);
        chk("reached_wr", {31'b0, mem_we}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_done", {31'b0, done}, 32'd0);
        chk("mid_rst_err", {31'b0, err}, 32'd0);
        chk("mid_rst_rdata", rdata, 32'd0);
        chk("mid_rst_mem_a", mem_a, 32'd0);
        chk("mid_rst_mem_wd", mem_wd, 32'd0);
        @(posedge clk); #1;
        chk("mem_word_kept", mem[2], 32'h11AB_3344);
        exp_q.delete();
        acc_q.delete();
        we_cnt = 0;
        @(negedge clk); #2 reset = 1'b1;
        @(posedge clk); #1;

        issue(0, 2'b10, 0, 32'h08, 0, 0, 2, 32'h11AB_3344, 0, 0, 0);

        n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
